// File: rtl/stopwatch_pkg.sv
// Shared BCD types and limits for the decade counter chain.
// MAX_DIGITS bounds the widest chain; BIN_W covers a binary count up to 10**MAX_DIGITS-1.
package stopwatch_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX  = 4'd9;
  localparam int         MAX_DIGITS = 4;
  localparam int         BIN_W      = 14;

  // Binary to packed BCD, digit 0 in bits [3:0]; only reached on the load path.
  function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input logic [BIN_W-1:0] v);
    logic [BIN_W-1:0]        r;
    logic [4*MAX_DIGITS-1:0] b;
    r = v;
    b = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      b[4*i +: 4] = 4'(r % BIN_W'(10));
      r           = r / BIN_W'(10);
    end
    return b;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control and status bundle of one bcd_mod_counter stage.
// load/load_val exist only when BCD_MOD_COUNTER_LOAD_EN is defined.
interface bcd_mod_counter_if #(
  parameter int W      = 7,
  parameter int DIGITS = 2
);

  logic                  en;
  logic                  up;
  logic                  clr;
`ifdef BCD_MOD_COUNTER_LOAD_EN
  logic                  load;
  logic [W-1:0]          load_val;
`endif
  logic [W-1:0]          count;
  logic [4*DIGITS-1:0]   bcd;
  logic                  tc;
  logic                  co;

`ifdef BCD_MOD_COUNTER_LOAD_EN
  modport master (output en, up, clr, load, load_val, input count, bcd, tc, co);
  modport slave  (input en, up, clr, load, load_val, output count, bcd, tc, co);
`else
  modport master (output en, up, clr, input count, bcd, tc, co);
  modport slave  (input en, up, clr, output count, bcd, tc, co);
`endif

endinterface

// File: rtl/bcd_mod_counter_digit.sv
// One registered decade 0..9 counting up or down on a carry/borrow strobe.
// carry is combinational: asserted when this step rolls the digit over.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       set,
  input  bcd_digit_t set_val,
  output bcd_digit_t digit,
  output logic       carry
);

  bcd_digit_t digit_q;

  assign digit = digit_q;
  assign carry = step & (up ? (digit_q == DIGIT_MAX) : (digit_q == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else if (set) begin
      digit_q <= set_val;
    end else if (step) begin
      if (up) begin
        digit_q <= (digit_q == DIGIT_MAX) ? 4'd0 : digit_q + 4'd1;
      end else begin
        digit_q <= (digit_q == 4'd0) ? DIGIT_MAX : digit_q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Modulo-MODULUS up/down counter with registered binary and BCD views, same-edge update.
// tc/co are combinational for cascading; BCD_MOD_COUNTER_LOAD_EN adds a clamped synchronous load.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = 100,
  parameter int DIGITS  = 2
) (
  input  logic            clk,
  input  logic            rst,
  bcd_mod_counter_if.slave bus
);

  localparam int           W   = $clog2(MODULUS);
  localparam logic [W-1:0] TOP = W'(MODULUS - 1);

  logic [W-1:0]        count_q;
  logic [W-1:0]        count_d;
  logic                tc;
  logic                step;
  logic                set;
  logic [4*DIGITS-1:0] set_bcd;
  logic [DIGITS:0]     carry;
  logic                unused_top_carry;
  bcd_digit_t          digits [DIGITS];

  function automatic logic [4*DIGITS-1:0] bcd_of(input logic [W-1:0] v);
    logic [4*MAX_DIGITS-1:0] f;
    f = to_bcd(BIN_W'(v));
    return f[4*DIGITS-1:0];
  endfunction

`ifdef BCD_MOD_COUNTER_LOAD_EN
  logic [W-1:0] load_clamp;
  assign load_clamp = (bus.load_val > TOP) ? TOP : bus.load_val;
`endif

  assign tc        = bus.up ? (count_q == TOP) : (count_q == '0);
  assign bus.tc    = tc;
  assign bus.co    = bus.en & tc;
  assign bus.count = count_q;

  // Wrap, clear and load all overwrite the whole digit chain; a plain step ripples from digit 0.
  always_comb begin
    count_d = count_q;
    step    = 1'b0;
    set     = 1'b0;
    set_bcd = '0;
    if (bus.clr) begin
      count_d = '0;
      set     = 1'b1;
    end
`ifdef BCD_MOD_COUNTER_LOAD_EN
    else if (bus.load) begin
      count_d = load_clamp;
      set     = 1'b1;
      set_bcd = bcd_of(load_clamp);
    end
`endif
    else if (bus.en) begin
      if (tc) begin
        count_d = bus.up ? '0 : TOP;
        set     = 1'b1;
        set_bcd = bus.up ? '0 : bcd_of(TOP);
      end else begin
        count_d = bus.up ? count_q + W'(1) : count_q - W'(1);
        step    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign carry[0] = step;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .step    (carry[g]),
      .up      (bus.up),
      .set     (set),
      .set_val (set_bcd[4*g +: 4]),
      .digit   (digits[g]),
      .carry   (carry[g+1])
    );
    assign bus.bcd[4*g +: 4] = digits[g];
  end

  // The modulus wrap always fires before the top digit could roll over.
  assign unused_top_carry = carry[DIGITS];

endmodule
